// File: rtl/led_breather.sv
// led_breather: PWM "breathing" LED driver sequenced by an upstream tick strobe
module led_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 4,
    parameter int HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tick,
    output logic       led,
    output logic [1:0] phase,
    output logic       cycle_done
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PWM_BITS-1:0] MAX_V = '1;
    localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {RISE = 2'd0, HIGH = 2'd1, FALL = 2'd2, LOW = 2'd3} state_t;

    state_t              state;
    logic [PWM_BITS-1:0] duty, active_duty, pwm_cnt, duty_up, duty_dn;
    logic [PWM_BITS:0]   sum;
    logic [HW-1:0]       hold_cnt;
    logic                hold_end;

    assign phase = state;

    // Saturating ramp steps; the sum is one bit wider so it cannot wrap
    always_comb begin
        sum      = {1'b0, duty} + {1'b0, STEP_V};
        duty_up  = sum > {1'b0, MAX_V} ? MAX_V : sum[PWM_BITS-1:0];
        duty_dn  = duty > STEP_V ? duty - STEP_V : '0;
        hold_end = hold_cnt == HOLD_LAST;
    end

    // Breathing sequencer: one action per tick, parked at RISE/0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RISE;
            duty       <= '0;
            hold_cnt   <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (!enable) begin
                state    <= RISE;
                duty     <= '0;
                hold_cnt <= '0;
            end else if (tick) begin
                case (state)
                    RISE: begin
                        duty <= duty_up;
                        if (duty_up == MAX_V) begin
                            state    <= HIGH;
                            hold_cnt <= '0;
                        end
                    end
                    HIGH: begin
                        state    <= hold_end ? FALL : HIGH;
                        hold_cnt <= hold_end ? '0 : hold_cnt + 1'b1;
                    end
                    FALL: begin
                        duty <= duty_dn;
                        if (duty_dn == '0) begin
                            state    <= LOW;
                            hold_cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= hold_end ? RISE : LOW;
                        hold_cnt   <= hold_end ? '0 : hold_cnt + 1'b1;
                        cycle_done <= hold_end;
                    end
                endcase
            end
        end
    end

    // Free-running PWM; duty is latched only at the period boundary to avoid glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            active_duty <= '0;
            led         <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX_V) active_duty <= duty;
            led <= enable & (pwm_cnt < active_duty);
        end
    end
endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: table vectors, corner sequences and random stimulus vs a tick-position model
module tb_led_breather;
    localparam int PB = 4, ST = 4, HT = 2;
    localparam int MAXV = (1 << PB) - 1;
    localparam int U = (MAXV + ST - 1) / ST;
    localparam int L = 2 * U + 2 * HT;

    logic       clk = 0, rst_n = 0, enable = 0, tick = 0;
    logic       led, cycle_done;
    logic [1:0] phase;

    int checks = 0, errors = 0;
    bit mon = 0;

    int p = 0, act = 0, pwm = 0;
    bit m_led = 0, m_cd = 0;

    typedef struct {
        bit en;
        bit tk;
        int ph;
        bit cd;
    } vec_t;
    vec_t vecs[24];
    int   tick_ph[12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0};

    led_breather #(.PWM_BITS(PB), .STEP(ST), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
        .led(led), .phase(phase), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int duty_of(int q);
        if (q < U) return (q * ST > MAXV) ? MAXV : q * ST;
        if (q < U + HT) return MAXV;
        if (q < 2 * U + HT) return (MAXV - (q - U - HT) * ST < 0) ? 0 : MAXV - (q - U - HT) * ST;
        return 0;
    endfunction

    function automatic int phase_of(int q);
        return q < U ? 0 : q < U + HT ? 1 : q < 2 * U + HT ? 2 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 0; act <= 0; pwm <= 0; m_led <= 0; m_cd <= 0;
        end else begin
            m_led <= enable && (pwm < act);
            if (pwm == MAXV) act <= duty_of(p);
            pwm  <= (pwm + 1) % (MAXV + 1);
            m_cd <= enable && tick && (p == L - 1);
            p    <= !enable ? 0 : tick ? (p + 1) % L : p;
        end
    end

    task automatic chk(string nm, int a, int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (mon && rst_n) begin
            chk("mon_led", int'(led), int'(m_led));
            chk("mon_phase", int'(phase), phase_of(p));
            chk("mon_cycle_done", int'(cycle_done), int'(m_cd));
        end
    end

    task automatic step(bit e, bit t);
        enable = e;
        tick = t;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; tick = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic period_count(output int n);
        int w;
        w = 0;
        n = 0;
        tick = 0;
        @(negedge clk);
        while (pwm != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) chk("period_sync_timeout", w, 0);
        for (int i = 0; i < MAXV + 1; i++) begin
            @(negedge clk);
            n += int'(led);
        end
    endtask

    initial begin
        int n, w;
        for (int i = 0; i < 12; i++) begin
            vecs[2*i]   = '{1'b1, 1'b1, tick_ph[i], i == 11};
            vecs[2*i+1] = '{1'b1, 1'b0, tick_ph[i], 1'b0};
        end

        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_cycle_done", int'(cycle_done), 0);
        rst_n = 1;
        mon = 1;

        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0);
            n += int'(led);
        end
        chk("idle_led_count", n, 0);
        chk("idle_phase", int'(phase), 0);

        do_reset();
        step(1, 0);
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].en, vecs[i].tk);
            chk($sformatf("tbl_phase_%0d", i), int'(phase), vecs[i].ph);
            chk($sformatf("tbl_cd_%0d", i), int'(cycle_done), int'(vecs[i].cd));
        end

        do_reset();
        repeat ($urandom_range(1, 15)) step(1, 0);
        step(1, 1);
        step(1, 1);
        period_count(n);
        chk("duty8_on_count", n, 8);

        do_reset();
        repeat (3) step(1, 0);
        repeat (3) step(1, 1);
        chk("held_tick_phase", int'(phase), 0);
        period_count(n);
        chk("held_tick_on_count", n, 12);
        step(1, 1);
        chk("held_tick_sat_phase", int'(phase), 1);

        do_reset();
        repeat (7) begin
            step(1, 1);
            step(1, 0);
        end
        chk("fall_phase", int'(phase), 2);
        step(0, 1);
        chk("drop_phase", int'(phase), 0);
        chk("drop_cd", int'(cycle_done), 0);
        chk("drop_led", int'(led), 0);
        step(0, 0);
        step(1, 0);
        step(1, 1);
        chk("reenable_phase", int'(phase), 0);
        period_count(n);
        chk("reenable_on_count", n, 4);

        do_reset();
        repeat (4) begin
            step(1, 1);
            step(1, 0);
        end
        chk("high_phase", int'(phase), 1);
        w = 0;
        while (led !== 1'b1 && w < 60) begin
            step(1, 0);
            w++;
        end
        chk("high_led_seen", int'(led), 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_phase", int'(phase), 0);
        chk("async_cd", int'(cycle_done), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 0);
        chk("post_rst_phase", int'(phase), 0);
        period_count(n);
        chk("post_rst_on_count", n, 0);

        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0);

        mon = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
